// File: rtl/conv_psum_accum.sv
// conv_psum_accum: per-lane partial-sum accumulator downstream of the conv core.
// Sums N = max(cfg_num_tiles,1) beats per output pixel and holds the result
// behind a valid/ready handshake. Optional macro CONV_PSUM_SAT_EN switches the
// per-lane adds from two's-complement wrap to saturation with a sticky flag.
module conv_psum_accum #(
  parameter int OC2_LANES = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_W-1:0]             cfg_num_tiles,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OC2_LANES*ACC_W-1:0]   partial,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OC2_LANES*OUT_W-1:0]   acc_out,
  output logic [CNT_W-1:0]             tile_cnt,
  output logic                         sat_flag
);

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        n_lat, n_cur, tile_cnt_nxt;
  logic                    beat, first, last;
  logic [OUT_W-1:0]        acc     [OC2_LANES];
  logic [OUT_W-1:0]        acc_nxt [OC2_LANES];
  logic [OUT_W-1:0]        psx     [OC2_LANES];
  logic [OUT_W-1:0]        sum     [OC2_LANES];
  logic signed [ACC_W-1:0] pin     [OC2_LANES];

  // In FULL, tile_cnt is always 0, so a beat taken while the result drains
  // is the first beat of the next group.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == FULL);
  assign beat      = in_valid && in_ready;
  assign first     = (tile_cnt == '0);
  assign n_cur     = first ? ((cfg_num_tiles == '0) ? CNT_W'(1) : cfg_num_tiles) : n_lat;
  assign last      = (tile_cnt == n_cur - CNT_W'(1));

  // Next-state and tile counter update.
  always_comb begin
    state_nxt    = state;
    tile_cnt_nxt = tile_cnt;
    if (beat) tile_cnt_nxt = last ? '0 : tile_cnt + CNT_W'(1);
    if (beat && last)                    state_nxt = FULL;
    else if (state == FULL && out_ready) state_nxt = ACCUM;
  end

`ifdef CONV_PSUM_SAT_EN
  logic sat_hit;
`endif

  // Per-lane sign extension, add and load/accumulate selection.
  always_comb begin
`ifdef CONV_PSUM_SAT_EN
    sat_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < OC2_LANES; i++) begin
      pin[i] = partial[i*ACC_W +: ACC_W];
      psx[i] = OUT_W'(pin[i]);
      sum[i] = acc[i] + psx[i];
      if (first) begin
        acc_nxt[i] = psx[i];
      end else begin
`ifdef CONV_PSUM_SAT_EN
        if ((acc[i][OUT_W-1] == psx[i][OUT_W-1]) && (sum[i][OUT_W-1] != acc[i][OUT_W-1])) begin
          acc_nxt[i] = acc[i][OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
          sat_hit    = 1'b1;
        end else begin
          acc_nxt[i] = sum[i];
        end
`else
        acc_nxt[i] = sum[i];
`endif
      end
    end
  end

  // Flatten the accumulator registers onto the output bus.
  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < OC2_LANES; i++) acc_out[i*OUT_W +: OUT_W] = acc[i];
  end

  // State, counter, latched group length and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      tile_cnt <= '0;
      n_lat    <= CNT_W'(1);
      for (int unsigned i = 0; i < OC2_LANES; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        tile_cnt <= tile_cnt_nxt;
        if (first) n_lat <= n_cur;
        for (int unsigned i = 0; i < OC2_LANES; i++) acc[i] <= acc_nxt[i];
      end
    end
  end

`ifdef CONV_PSUM_SAT_EN
  // Sticky saturation indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                 sat_flag <= 1'b0;
    else if (beat && sat_hit) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
